datapath_sequencer: RTL

Fetch/decode/execute controller for the 16-register datapath. It latches the 16-bit word on current_instruction and decodes it. It then drives every datapath control input for one or two cycles per instruction. It also handles program-counter updates (register 0), conditional branches, VGA plot requests, halt/restart and an instruction-retire counter. It sits between the instruction stream and the datapath and is the only driver of the datapath control inputs.

---
 rtl/datapath_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: fetch/decode/execute controller for the 16-register datapath.
// Latches the instruction word, then drives all datapath controls for one cycle
// (two for LOAD) per instruction, and counts retired instructions.
// Optional build macro: CTRL_TRAP_EN -- adds a two-cycle TRAP sequence taken when an
// ALU/ADDI instruction targets a register whose error flag is set.
module datapath_sequencer #(
    parameter logic [15:0] TRAP_VECTOR = 16'h0010,
    parameter logic [3:0]  TRAP_LINK   = 4'hF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] current_instruction,
    input  logic [15:0] zeroflag,
    input  logic [15:0] errorbit,
    output logic        program_counter_increment,
    output logic [3:0]  alu_op,
    output logic [3:0]  alu_a_select,
    output logic [3:0]  alu_b_select,
    output logic        alu_a_source,
    output logic        alu_b_source,
    output logic [15:0] alu_a_altern,
    output logic [15:0] alu_b_altern,
    output logic [3:0]  alu_out_select,
    output logic [1:0]  alu_load_src,
    output logic        alu_store_to_mem,
    output logic        alu_store_to_stk,
    output logic [3:0]  vga_color_select,
    output logic [3:0]  vga_coord_select,
    output logic        vga_plot,
    output logic        halted,
    output logic [15:0] instr_count
);

`ifdef CTRL_TRAP_EN
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT, S_TRAP1, S_TRAP2} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;
    // Trap controls do not exist in this build; keep the inputs visibly consumed.
    logic unused_trap;
    assign unused_trap = ^{errorbit, TRAP_VECTOR, TRAP_LINK};
`endif

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] cnt_q, cnt_d;
    logic        retire;

    logic [3:0] opc, rd, ra, rb;
    logic [7:0] imm8;
    assign opc  = ir_q[15:12];
    assign rd   = ir_q[11:8];
    assign ra   = ir_q[7:4];
    assign rb   = ir_q[3:0];
    assign imm8 = ir_q[7:0];

    assign halted           = (state_q == S_HALT);
    assign instr_count      = cnt_q;
    assign alu_store_to_stk = 1'b0;

    // State, instruction register and retire counter; reset aborts any instruction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ir_q    <= 16'h0000;
            cnt_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and datapath controls, decoded from state and the latched instruction.
    always_comb begin
        state_d                   = state_q;
        ir_d                      = ir_q;
        retire                    = 1'b0;
        program_counter_increment = 1'b0;
        alu_op                    = 4'h0;
        alu_a_select              = 4'h0;
        alu_b_select              = 4'h0;
        alu_a_source              = 1'b0;
        alu_b_source              = 1'b0;
        alu_a_altern              = 16'h0000;
        alu_b_altern              = 16'h0000;
        alu_out_select            = 4'h0;
        alu_load_src              = 2'b00;
        alu_store_to_mem          = 1'b0;
        vga_color_select          = 4'h0;
        vga_coord_select          = 4'h0;
        vga_plot                  = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: if (start) state_d = S_FETCH;
            S_FETCH: begin
                ir_d    = current_instruction;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                retire  = 1'b1;
                case (opc)
                    4'h0: program_counter_increment = 1'b1;
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                        alu_op                    = opc;
                        alu_a_select              = ra;
                        alu_b_select              = rb;
                        alu_out_select            = rd;
                        alu_load_src              = 2'b01;
                        program_counter_increment = 1'b1;
                    end
                    4'h8: begin
                        alu_op                    = 4'h1;
                        alu_b_source              = 1'b1;
                        alu_b_altern              = {12'h000, rb};
                        alu_a_select              = ra;
                        alu_out_select            = rd;
                        alu_load_src              = 2'b01;
                        program_counter_increment = 1'b1;
                    end
                    4'h9: begin
                        alu_a_source              = 1'b1;
                        alu_a_altern              = {8'h00, imm8};
                        alu_out_select            = rd;
                        alu_load_src              = 2'b01;
                        program_counter_increment = 1'b1;
                    end
                    4'hA: begin
                        // Address phase only; the register write happens in MEM.
                        alu_a_select = ra;
                        state_d      = S_MEM;
                        retire       = 1'b0;
                    end
                    4'hB: begin
                        alu_a_select              = ra;
                        alu_out_select            = rd;
                        alu_store_to_mem          = 1'b1;
                        program_counter_increment = 1'b1;
                    end
                    4'hC, 4'hD: begin
                        // JMP always, BRZ only when the tested register is zero: PC <= ra.
                        if (opc == 4'hC || zeroflag[rd]) begin
                            alu_a_select = ra;
                            alu_load_src = 2'b01;
                        end else begin
                            program_counter_increment = 1'b1;
                        end
                    end
                    4'hE: begin
                        vga_color_select          = rd;
                        vga_coord_select          = ra;
                        vga_plot                  = 1'b1;
                        program_counter_increment = 1'b1;
                    end
                    default: state_d = S_HALT;
                endcase
`ifdef CTRL_TRAP_EN
                if (opc >= 4'h1 && opc <= 4'h8 && errorbit[rd]) state_d = S_TRAP1;
`endif
            end
            S_MEM: begin
                alu_a_select              = ra;
                alu_load_src              = 2'b10;
                alu_out_select            = rd;
                program_counter_increment = 1'b1;
                retire                    = 1'b1;
                state_d                   = S_FETCH;
            end
`ifdef CTRL_TRAP_EN
            S_TRAP1: begin
                // Link register <= PC (register 0 passed through the ALU).
                alu_out_select = TRAP_LINK;
                alu_load_src   = 2'b01;
                state_d        = S_TRAP2;
            end
            S_TRAP2: begin
                alu_a_source   = 1'b1;
                alu_a_altern   = TRAP_VECTOR;
                alu_load_src   = 2'b01;
                state_d        = S_FETCH;
            end
`endif
            default: state_d = S_IDLE;
        endcase
        cnt_d = retire ? cnt_q + 16'h0001 : cnt_q;
    end

endmodule
